// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default stage indices for the pipeline controller.
// Stage indices below describe the classic five-stage arrangement.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        FETCH_DROP = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DROP = FETCH_DROP;

    localparam int IF_S   = 0;
    localparam int ID_S   = 1;
    localparam int EX_S   = 2;
    localparam int MEM_S  = 3;
    localparam int WB_S   = 4;
    localparam int RA_W_D = 5;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = WB_S + 1,
    parameter int RA_W   = RA_W_D
);
    logic              fetch_busy;
    logic              mem_busy;
    logic              redirect;
    logic              ex_memread;
    logic [RA_W-1:0]   ex_dst;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic [NSTAGE-1:0] stage_valid;
    logic [NSTAGE-1:0] stage_en;
    logic              pc_en;
    logic              fetch_drop;
    logic              commit;
    logic [63:0]       instret;
    logic [63:0]       perf_mem;
    logic [63:0]       perf_lu;
    logic [63:0]       perf_flush;

    modport master (
        output fetch_busy, mem_busy, redirect, ex_memread, ex_dst, id_rs1, id_rs2,
        input  stage_valid, stage_en, pc_en, fetch_drop, commit, instret,
        input  perf_mem, perf_lu, perf_flush
    );

    modport slave (
        input  fetch_busy, mem_busy, redirect, ex_memread, ex_dst, id_rs1, id_rs2,
        output stage_valid, stage_en, pc_en, fetch_drop, commit, instret,
        output perf_mem, perf_lu, perf_flush
    );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Enable-gated 64-bit event counter with asynchronous active-low clear.
// Only compiled when PIPE_CTRL_PERF_EN is defined, the sole build that uses it.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [63:0] count
);
    logic [63:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_reg <= '0;
        else if (en)
            count_reg <= count_reg + 64'd1;
    end

    assign count = count_reg;
endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Stall/flush/valid controller for the in-order pipeline: stage valids, load enables, PC enable, instret.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE    = WB_S + 1,
    parameter int EX_STAGE  = EX_S,
    parameter int MEM_STAGE = MEM_S,
    parameter int RA_W      = RA_W_D
) (
    input  logic       clk,
    input  logic       reset,
    pipe_ctrl_if.slave bus
);
    logic [1:0]        state_reg, state_next;
    logic [NSTAGE-1:1] valid_reg, valid_next;
    logic [NSTAGE-1:0] stage_valid, stage_en;
    logic [NSTAGE-1:1] hold, bubble;
    logic [RA_W-1:0]   ex_dst, id_rs1, id_rs2;
    logic [63:0]       instret_reg;
    logic              running, lu, take, no_freeze;

    assign ex_dst  = bus.ex_dst;
    assign id_rs1  = bus.id_rs1;
    assign id_rs2  = bus.id_rs2;
    assign running = (state_reg != ST_BOOT);

    assign stage_valid = {valid_reg, (state_reg == ST_RUN) & ~bus.fetch_busy};

    assign lu = stage_valid[EX_STAGE] & bus.ex_memread & (ex_dst != '0)
              & ((ex_dst == id_rs1) | (ex_dst == id_rs2)) & stage_valid[EX_STAGE-1];

    // A redirect raised under a dbus wait stays pending until MEM releases.
    assign take      = bus.redirect & stage_valid[EX_STAGE] & ~bus.mem_busy;
    assign no_freeze = ~bus.mem_busy & ~lu;

    assign stage_en[0] = 1'b0;

    // Register gi holds at or below the freeze point and takes a bubble just above it.
    generate
        for (genvar gi = 1; gi < NSTAGE; gi++) begin : g_stage
            localparam bit HOLD_MEM = (gi <= MEM_STAGE);
            localparam bit BUB_MEM  = (gi == MEM_STAGE + 1);
            localparam bit HOLD_LU  = (gi <= EX_STAGE - 1);
            localparam bit BUB_LU   = (gi == EX_STAGE);
            localparam bit KILLABLE = (gi <= EX_STAGE);

            assign hold[gi]   = bus.mem_busy ? HOLD_MEM : (lu & HOLD_LU);
            assign bubble[gi] = bus.mem_busy ? BUB_MEM  : (lu & BUB_LU);

            assign stage_en[gi]   = running & ~hold[gi];
            assign valid_next[gi] = stage_en[gi]
                                  ? (~bubble[gi] & stage_valid[gi-1] & ~(take & KILLABLE))
                                  : valid_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (take & bus.fetch_busy) state_next = ST_DROP;
            ST_DROP: if (~bus.fetch_busy) state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_BOOT;
            valid_reg   <= '0;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            instret_reg <= instret_reg + {63'd0, stage_valid[NSTAGE-1]};
        end
    end

    assign bus.stage_valid = stage_valid;
    assign bus.stage_en    = stage_en;
    assign bus.pc_en       = take | (running & no_freeze & ~bus.fetch_busy);
    assign bus.fetch_drop  = (state_reg == ST_DROP) & ~bus.fetch_busy;
    assign bus.commit      = stage_valid[NSTAGE-1];
    assign bus.instret     = instret_reg;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf_mem (
        .clk   (clk),
        .reset (reset),
        .en    (bus.mem_busy & (state_reg == ST_RUN)),
        .count (bus.perf_mem)
    );
    pipe_perf_cnt u_perf_lu (
        .clk   (clk),
        .reset (reset),
        .en    (lu & ~bus.mem_busy),
        .count (bus.perf_lu)
    );
    pipe_perf_cnt u_perf_flush (
        .clk   (clk),
        .reset (reset),
        .en    (take),
        .count (bus.perf_flush)
    );
`else
    assign bus.perf_mem   = '0;
    assign bus.perf_lu    = '0;
    assign bus.perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: an instruction-tag pipeline model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_pipe_ctrl;
    localparam int N   = 5;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int RW  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl_if #(.NSTAGE(N), .RA_W(RW)) bus ();

    pipe_ctrl #(.NSTAGE(N), .EX_STAGE(EX), .MEM_STAGE(MEM), .RA_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: each stage carries an instruction tag (0 = empty); tags make lost or duplicated work visible.
    int              m_state;   // 0 boot, 1 run, 2 waiting to drop a stale fetch
    int              slot [N];
    int              next_id;
    longint unsigned m_instret, m_pmem, m_plu, m_pflush;

    task automatic model_reset();
        m_state = 0;
        foreach (slot[k]) slot[k] = 0;
        next_id   = 1;
        m_instret = 0;
        m_pmem    = 0;
        m_plu     = 0;
        m_pflush  = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] ev, een;
        int  nslot [N];
        int  fid, frz;
        bit  lu, take, cmt, pce, drop;
        fid   = (m_state == 1 && !bus.fetch_busy) ? next_id : 0;
        ev[0] = (fid != 0);
        for (int k = 1; k < N; k++) ev[k] = (slot[k] != 0);
        lu   = ev[EX] && bus.ex_memread && bus.ex_dst != 0 &&
               (bus.ex_dst == bus.id_rs1 || bus.ex_dst == bus.id_rs2) && ev[EX-1];
        take = bus.redirect && ev[EX] && !bus.mem_busy;
        frz  = bus.mem_busy ? MEM : (lu ? EX - 1 : -1);
        een  = '0;
        nslot = slot;
        for (int k = N - 1; k >= 1; k--) begin
            if (m_state != 0 && k > frz) begin
                een[k] = 1'b1;
                if (k == frz + 1 || (take && k <= EX)) nslot[k] = 0;
                else nslot[k] = (k == 1) ? fid : slot[k-1];
            end
        end
        cmt  = (slot[N-1] != 0);
        pce  = take || (m_state != 0 && frz < 0 && !bus.fetch_busy);
        drop = (m_state == 2) && !bus.fetch_busy;

        chk("stage_valid", bus.stage_valid, ev);
        chk("stage_en", bus.stage_en, een);
        chk("pc_en", bus.pc_en, pce);
        chk("fetch_drop", bus.fetch_drop, drop);
        chk("commit", bus.commit, cmt);
        chk("instret", bus.instret, m_instret);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_mem", bus.perf_mem, m_pmem);
        chk("perf_lu", bus.perf_lu, m_plu);
        chk("perf_flush", bus.perf_flush, m_pflush);
`else
        chk("perf_tied", bus.perf_mem | bus.perf_lu | bus.perf_flush, 64'd0);
`endif

        if (een[1] && nslot[1] != 0) next_id++;
        slot = nslot;
        m_instret += cmt;
        m_pmem    += (bus.mem_busy && m_state == 1);
        m_plu     += (lu && !bus.mem_busy);
        m_pflush  += take;
        case (m_state)
            0: m_state = 1;
            1: if (take && bus.fetch_busy) m_state = 2;
            default: if (!bus.fetch_busy) m_state = 1;
        endcase
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            model_reset();
            chk("rst_valid", bus.stage_valid, 64'd0);
            chk("rst_en", bus.stage_en, 64'd0);
            chk("rst_pc_en", bus.pc_en, 64'd0);
            chk("rst_instret", bus.instret, 64'd0);
            chk("rst_perf", bus.perf_mem | bus.perf_lu | bus.perf_flush, 64'd0);
        end else begin
            model_step();
        end
    end

    task automatic drive(input bit rst, input bit fb, input bit mb, input bit rd, input bit mr,
                         input logic [4:0] dst, input logic [4:0] rs1, input logic [4:0] rs2);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.fetch_busy = fb;
        bus.mem_busy   = mb;
        bus.redirect   = rd;
        bus.ex_memread = mr;
        bus.ex_dst     = dst;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        @(negedge clk);
        #1;
        $display("cyc t=%0t rst=%0b fb=%0b mb=%0b rd=%0b lu_in=%0b sv=%b en=%b pc_en=%0b drop=%0b commit=%0b instret=%0d",
                 $time, rst, fb, mb, rd, mr, bus.stage_valid, bus.stage_en, bus.pc_en,
                 bus.fetch_drop, bus.commit, bus.instret);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.fetch_busy = 1'b0;
        bus.mem_busy   = 1'b0;
        bus.redirect   = 1'b0;
        bus.ex_memread = 1'b0;
        bus.ex_dst     = '0;
        bus.id_rs1     = '0;
        bus.id_rs2     = '0;
        model_reset();

        repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Reset release, fill and steady flow
        for (int c = 1; c <= 15; c++) begin
            idle();
            if (c == 1) chk("boot_pc_en", bus.pc_en, 64'd0);
            if (c == 2) begin
                chk("first_pc_en", bus.pc_en, 64'd1);
                chk("first_fetch", bus.stage_valid, 64'h01);
            end
            if (c == 5) chk("no_commit_yet", bus.commit, 64'd0);
            if (c == 6) chk("first_commit", bus.commit, 64'd1);
            if (c == 15) begin
                chk("full_pipe", bus.stage_valid, 64'h1f);
                chk("instret_9", bus.instret, 64'd9);
            end
        end

        // Load-use on rs1
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        chk("lu_en", bus.stage_en, 64'h1c);
        chk("lu_pc_en", bus.pc_en, 64'd0);
        idle();
        chk("lu_bubble", bus.stage_valid, 64'h1b);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_lu_1", bus.perf_lu, 64'd1);
`endif
        idle();
        // Load-use on rs2
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7);
        chk("lu2_en", bus.stage_en, 64'h1c);
        idle();
        idle();
        // Load to x0 never interlocks
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("x0_en", bus.stage_en, 64'h1e);
        chk("x0_pc_en", bus.pc_en, 64'd1);

        // fetch_busy alone bubbles only stage 1
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("fb_en", bus.stage_en, 64'h1e);
        chk("fb_pc_en", bus.pc_en, 64'd0);
        chk("fb_if_valid", {63'd0, bus.stage_valid[0]}, 64'd0);
        repeat (4) idle();

        // mem_busy held 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            chk("mb_en", bus.stage_en, 64'h10);
            if (i > 0) chk("mb_commit", bus.commit, 64'd0);
        end
        idle();
        chk("mb_release_commit", bus.commit, 64'd0);
        idle();
        chk("mb_resume_commit", bus.commit, 64'd1);
        repeat (3) idle();

        // Redirect while a fetch is outstanding
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("rd_pc_en", bus.pc_en, 64'd1);
        chk("rd_en", bus.stage_en, 64'h1e);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("rd_flushed", {62'd0, bus.stage_valid[2:1]}, 64'd0);
        chk("rd_wait_drop", bus.fetch_drop, 64'd0);
        idle();
        chk("rd_drop", bus.fetch_drop, 64'd1);
        chk("rd_drop_if", {63'd0, bus.stage_valid[0]}, 64'd0);
        idle();
        chk("rd_after_drop", bus.fetch_drop, 64'd0);
        chk("rd_refetch", {63'd0, bus.stage_valid[0]}, 64'd1);
        repeat (5) idle();

        // Redirect deferred by mem_busy, taken on release
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
            chk("drd_pc_en", bus.pc_en, 64'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("drd_take", bus.pc_en, 64'd1);
        idle();
        chk("drd_flushed", {62'd0, bus.stage_valid[2:1]}, 64'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_flush_2", bus.perf_flush, 64'd2);
`endif
        repeat (3) idle();

        // Reset asserted in the middle of a dbus wait
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("mid_rst_valid", bus.stage_valid, 64'd0);
        chk("mid_rst_instret", bus.instret, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int c = 1; c <= 8; c++) begin
            idle();
            if (c == 8) chk("post_rst_instret", bus.instret, 64'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
